// File: rtl/plru_array.sv
// plru_array: per-set tree pseudo-LRU state with one lookup port, one touch
// port and a background flush sweep.
//
// Ports
//   clk0, rst0_n        clock, async active-low reset
//   csb0, addr0         lookup select (active-low) and set index
//   dout0, victim0      tree bits / replacement way of the held lookup set
//   csb1, web1          touch select and write enable (both active-low)
//   addr1, way1         set and way to mark most-recently-used
//   flush_req           one-cycle request to clear every set
//   flush_busy          high for the NUM_SETS cycles of the sweep
//
// Tree: node 0 is the root, node i has children 2i+1 (lower ways) and 2i+2.
// A node bit points toward the LRU side (0 = left, 1 = right).
module plru_array #(
  parameter int S_INDEX  = 4,
  parameter int NUM_WAYS = 4,
  localparam int NUM_SETS = 2**S_INDEX,
  localparam int WIDTH    = NUM_WAYS-1,
  localparam int WAYW     = $clog2(NUM_WAYS)
) (
  input  logic               clk0,
  input  logic               rst0_n,
  input  logic               csb0,
  input  logic [S_INDEX-1:0] addr0,
  output logic [WIDTH-1:0]   dout0,
  output logic [WAYW-1:0]    victim0,
  input  logic               csb1,
  input  logic               web1,
  input  logic [S_INDEX-1:0] addr1,
  input  logic [WAYW-1:0]    way1,
  input  logic               flush_req,
  output logic               flush_busy
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [S_INDEX-1:0] cnt_q;
  logic [S_INDEX-1:0] addr0_q;
  logic               t_vld_q;
  logic [S_INDEX-1:0] t_addr_q;
  logic [WAYW-1:0]    t_way_q;
  logic [WIDTH-1:0]   mem [NUM_SETS];

  logic               idle_go;   // idle and not about to start a sweep
  logic               commit;
  logic [WIDTH-1:0]   touch_nxt;
  logic [WIDTH-1:0]   rd0;

  // Walk root-to-leaf along way's bits (MSB first), pointing each node away.
  function automatic logic [WIDTH-1:0] touch_fn(input logic [WIDTH-1:0] cur,
                                                 input logic [WAYW-1:0]  way);
    logic [WIDTH-1:0] nxt;
    int node;
    nxt  = cur;
    node = 0;
    for (int l = 0; l < WAYW; l++) begin
      nxt[node] = ~way[WAYW-1-l];
      node      = 2*node + 1 + int'(way[WAYW-1-l]);
    end
    return nxt;
  endfunction

  function automatic logic [WAYW-1:0] victim_fn(input logic [WIDTH-1:0] bits);
    int node;
    node = 0;
    for (int l = 0; l < WAYW; l++)
      node = 2*node + 1 + int'(bits[node]);
    return WAYW'(node - WIDTH);
  endfunction

  // A flush request wins over the touch pending on the same edge.
  assign idle_go   = (state_q == IDLE) && !flush_req;
  assign commit    = t_vld_q && idle_go;
  assign touch_nxt = touch_fn(mem[t_addr_q], t_way_q);

  // Forward the not-yet-written touch so the lookup never sees stale bits.
  always_comb begin
    rd0 = mem[addr0_q];
    if (commit && (t_addr_q == addr0_q)) rd0 = touch_nxt;
  end

  assign dout0      = rd0;
  assign victim0    = victim_fn(rd0);
  assign flush_busy = (state_q == FLUSH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (cnt_q == S_INDEX'(NUM_SETS-1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Counter wraps back to 0 on the last sweep cycle.
      if (state_q == FLUSH) cnt_q <= cnt_q + S_INDEX'(1);
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      addr0_q  <= '0;
      t_vld_q  <= 1'b0;
      t_addr_q <= '0;
      t_way_q  <= '0;
    end else begin
      if (!csb0 && state_q == IDLE) addr0_q <= addr0;
      t_vld_q <= idle_go && !csb1 && !web1;
      if (idle_go && !csb1 && !web1) begin
        t_addr_q <= addr1;
        t_way_q  <= way1;
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
    end else if (state_q == FLUSH) begin
      mem[cnt_q] <= '0;
    end else if (commit) begin
      mem[t_addr_q] <= touch_nxt;
    end
  end

endmodule

// File: tb/tb_plru_array.sv
// Directed bench for plru_array (S_INDEX=4, NUM_WAYS=4). Inputs change and
// outputs are sampled on the falling edge; dout0 is {b2,b1,b0}.
module tb_plru_array;
  logic       clk0 = 1'b0;
  logic       rst0_n;
  logic       csb0, csb1, web1, flush_req;
  logic [3:0] addr0, addr1;
  logic [1:0] way1, victim0;
  logic [2:0] dout0;
  logic       flush_busy;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt;

  plru_array #(.S_INDEX(4), .NUM_WAYS(4)) dut (
    .clk0(clk0), .rst0_n(rst0_n),
    .csb0(csb0), .addr0(addr0), .dout0(dout0), .victim0(victim0),
    .csb1(csb1), .web1(web1), .addr1(addr1), .way1(way1),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk0);
  endtask

  task automatic look(input logic [3:0] a);
    csb0 = 1'b0; addr0 = a; cyc();
  endtask

  // Returns on the falling edge after the touch is registered (still pending).
  task automatic touch(input logic [3:0] a, input logic [1:0] w);
    csb1 = 1'b0; web1 = 1'b0; addr1 = a; way1 = w; cyc();
    csb1 = 1'b1; web1 = 1'b1;
  endtask

  task automatic out_chk(input string tag, input logic [2:0] d, input logic [1:0] v);
    chk({tag, "_dout"}, 32'(dout0), 32'(d));
    chk({tag, "_vic"},  32'(victim0), 32'(v));
  endtask

  initial begin
    rst0_n = 1'b0; csb0 = 1'b1; csb1 = 1'b1; web1 = 1'b1; flush_req = 1'b0;
    addr0 = '0; addr1 = '0; way1 = '0;
    repeat (2) cyc();
    out_chk("rst", 3'b000, 2'd0);
    chk("rst_busy", 32'(flush_busy), 32'd0);
    rst0_n = 1'b1;
    cyc();

    // Fresh set reads zero, victim way 0.
    look(4'd5);
    out_chk("look5", 3'b000, 2'd0);

    // Touch way 0 then way 2 on set 5, lookup held on set 5.
    touch(4'd5, 2'd0);
    out_chk("fwd5w0", 3'b011, 2'd2);
    cyc();
    out_chk("arr5w0", 3'b011, 2'd2);
    touch(4'd5, 2'd2);
    out_chk("fwd5w2", 3'b110, 2'd1);
    cyc();
    out_chk("arr5w2", 3'b110, 2'd1);

    // Set 3 way 3: path bits b0,b2 cleared, still all zero.
    look(4'd3);
    touch(4'd3, 2'd3);
    out_chk("fwd3w3", 3'b000, 2'd0);
    cyc();
    out_chk("arr3w3", 3'b000, 2'd0);

    // Set 7 way 1: b0=1, b1=0 -> victim way 2.
    look(4'd7);
    touch(4'd7, 2'd1);
    out_chk("fwd7w1", 3'b001, 2'd2);
    cyc();
    out_chk("arr7w1", 3'b001, 2'd2);

    // Back-to-back touches on set 6 (way 0 then way 3) accumulate to 010.
    look(4'd6);
    csb1 = 1'b0; web1 = 1'b0; addr1 = 4'd6; way1 = 2'd0; cyc();
    way1 = 2'd3; cyc();
    csb1 = 1'b1; web1 = 1'b1;
    out_chk("fwd6acc", 3'b010, 2'd1);
    cyc();
    out_chk("arr6acc", 3'b010, 2'd1);

    // Touch every set with way 1, then flush.
    for (int s = 0; s < 16; s++) begin
      csb1 = 1'b0; web1 = 1'b0; addr1 = 4'(s); way1 = 2'd1; cyc();
    end
    csb1 = 1'b1; web1 = 1'b1;
    cyc();
    look(4'd10);
    out_chk("pre_flush10", 3'b001, 2'd2);

    flush_req = 1'b1; cyc(); flush_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 40 && flush_busy; k++) begin
      busy_cnt++;
      // Touches and repeated requests while busy must be ignored.
      csb1 = 1'b0; web1 = 1'b0; addr1 = 4'(k); way1 = 2'd0; flush_req = 1'b1;
      cyc();
    end
    csb1 = 1'b1; web1 = 1'b1; flush_req = 1'b0;
    chk("flush_len", 32'(busy_cnt), 32'd16);
    cyc();
    chk("flush_idle", 32'(flush_busy), 32'd0);
    for (int s = 0; s < 16; s++) begin
      look(4'(s));
      chk($sformatf("flushed%0d", s), 32'(dout0), 32'd0);
    end

    // Reset in the middle of a sweep.
    touch(4'd9, 2'd1);
    cyc();
    look(4'd9);
    out_chk("pre_rst9", 3'b001, 2'd2);
    flush_req = 1'b1; cyc(); flush_req = 1'b0;
    repeat (6) cyc();
    chk("mid_busy", 32'(flush_busy), 32'd1);
    rst0_n = 1'b0;
    #1;
    chk("abort_busy", 32'(flush_busy), 32'd0);
    out_chk("abort", 3'b000, 2'd0);
    cyc();
    rst0_n = 1'b1;
    cyc();
    chk("post_busy", 32'(flush_busy), 32'd0);
    look(4'd9);
    out_chk("post9", 3'b000, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
